// File: rtl/nios_jtag_debug_cmd_sync.sv
// nios_jtag_debug_cmd_sync: system-clock side of the JTAG debug bridge.
// Synchronises the TCK-domain update-DR/update-IR strobes, queues {ir_in, sr}
// on each update-DR in a first-word-fall-through command FIFO, and presents
// the head to the OCI logic with a valid/ready handshake and a one-hot take.
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   vs_udr, vs_uir         update-DR / update-IR levels (asynchronous)
//   ir_in, sr              quasi-static instruction and scan register
//   cmd_valid, cmd_ready   head handshake
//   cmd_ir, cmd_take, jdo  head instruction, its one-hot, head data
//   cur_ir                 instruction latched at the last update-IR
//   fifo_level             occupied entries (0..FIFO_DEPTH)
//   overrun, drop_cnt      sticky drop flag and saturating drop count
//   overrun_clr            clears overrun and drop_cnt
module nios_jtag_debug_cmd_sync #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [SR_W-1:0]                 sr,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [IR_W-1:0]                 cmd_ir,
    output logic [(1<<IR_W)-1:0]            cmd_take,
    output logic [SR_W-1:0]                 jdo,
    output logic [IR_W-1:0]                 cur_ir,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overrun,
    input  logic                            overrun_clr,
    output logic [7:0]                      drop_cnt
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int NCH = 1 << IR_W;
    localparam int EW  = IR_W + SR_W;

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
    logic                   udr_prev_q, udr_prev_d, uir_prev_q, uir_prev_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [EW-1:0]          hold_q, hold_d, head;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [IR_W-1:0]        cur_ir_q, cur_ir_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   dr_ev, ir_ev, full, pop, push_ok, drop;

    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        dr_ev      = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
        ir_ev      = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
        full       = level_q == LW'(FIFO_DEPTH);
        cmd_valid  = level_q != '0;
        pop        = cmd_valid && cmd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok    = dr_ev && (!full || pop);
        drop       = dr_ev && full && !pop;
        head       = mem_q[rd_ptr_q];
        mem_d      = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = {ir_in, sr};
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d    = (push_ok && !pop) ? level_q + LW'(1) :
                     (!push_ok && pop) ? level_q - LW'(1) : level_q;
        // Keep the last popped head visible once the FIFO runs empty.
        hold_d     = pop ? head : hold_q;
        cur_ir_d   = ir_ev ? ir_in : cur_ir_q;
        // A drop in the same cycle as a clear wins and restarts the count at 1.
        overrun_d  = drop ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
        drop_cnt_d = drop ? (overrun_clr ? 8'd1 : drop_cnt_q + {7'd0, drop_cnt_q != 8'hFF}) :
                     overrun_clr ? 8'd0 : drop_cnt_q;
        cmd_ir     = cmd_valid ? head[EW-1:SR_W] : hold_q[EW-1:SR_W];
        jdo        = cmd_valid ? head[SR_W-1:0] : hold_q[SR_W-1:0];
        cmd_take   = cmd_valid ? {{(NCH-1){1'b0}}, 1'b1} << cmd_ir : '0;
        cur_ir     = cur_ir_q;
        fifo_level = level_q;
        overrun    = overrun_q;
        drop_cnt   = drop_cnt_q;
    end

    // Synchroniser and edge-detect flops reset high so a strobe held across
    // reset release must fall and rise again before it counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '1;
            uir_sync_q <= '1;
            udr_prev_q <= 1'b1;
            uir_prev_q <= 1'b1;
            mem_q      <= '{default: '0};
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cur_ir_q   <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            udr_sync_q <= udr_sync_d;
            uir_sync_q <= uir_sync_d;
            udr_prev_q <= udr_prev_d;
            uir_prev_q <= uir_prev_d;
            mem_q      <= mem_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cur_ir_q   <= cur_ir_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_nios_jtag_debug_cmd_sync.sv
// tb_nios_jtag_debug_cmd_sync: directed self-checking bench for the command synchroniser.
module tb_nios_jtag_debug_cmd_sync;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        vs_udr, vs_uir, cmd_ready, overrun_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid, overrun;
    logic [1:0]  cmd_ir, cur_ir;
    logic [3:0]  cmd_take;
    logic [37:0] jdo;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    nios_jtag_debug_cmd_sync dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_take(cmd_take), .jdo(jdo), .cur_ir(cur_ir),
        .fifo_level(fifo_level), .overrun(overrun), .overrun_clr(overrun_clr),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full update-DR strobe: push lands on the 3rd edge, level held 4 then low 4.
    task automatic dr_pulse(input logic [37:0] d, input logic [1:0] ir);
        sr     = d;
        ir_in  = ir;
        vs_udr = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    initial begin
        reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; cmd_ready = 1'b0;
        overrun_clr = 1'b0; ir_in = '0; sr = '0;
        tick(3);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_take", cmd_take, 0);
        chk("rst_jdo", jdo, 0);
        chk("rst_cmd_ir", cmd_ir, 0);
        chk("rst_cur_ir", cur_ir, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;
        tick(10);
        chk("hold_valid", cmd_valid, 0);
        chk("hold_level", fifo_level, 0);

        vs_udr = 1'b0;
        tick(4);
        sr = 38'h2A_DEAD_BEEF; ir_in = 2'd2; vs_udr = 1'b1;
        tick(2);
        chk("lat_early", cmd_valid, 0);
        tick();
        chk("lat_valid", cmd_valid, 1);
        chk("lat_jdo", jdo, 38'h2A_DEAD_BEEF);
        chk("lat_take", cmd_take, 4'b0100);
        chk("lat_cmd_ir", cmd_ir, 2);
        chk("lat_level", fifo_level, 1);
        tick();
        vs_udr = 1'b0;
        tick(4);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("pop_valid", cmd_valid, 0);
        chk("pop_take", cmd_take, 0);
        chk("pop_jdo_hold", jdo, 38'h2A_DEAD_BEEF);
        chk("pop_ir_hold", cmd_ir, 2);

        ir_in = 2'd3; vs_uir = 1'b1;
        tick(2);
        chk("ir_early", cur_ir, 0);
        tick();
        chk("ir_cur", cur_ir, 3);
        chk("ir_level", fifo_level, 0);
        tick();
        vs_uir = 1'b0;
        tick(4);

        for (int i = 1; i <= 5; i++) dr_pulse(38'(i), 2'd1);
        chk("fill_level", fifo_level, 4);
        chk("fill_overrun", overrun, 1);
        chk("fill_drop", drop_cnt, 1);
        chk("fill_take", cmd_take, 4'b0010);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_jdo", jdo, 64'(i));
            tick();
        end
        cmd_ready = 1'b0;
        chk("drain_valid", cmd_valid, 0);
        chk("drain_level", fifo_level, 0);
        chk("drain_hold", jdo, 4);

        for (int i = 10; i <= 13; i++) dr_pulse(38'(i), 2'd0);
        chk("fp_full", fifo_level, 4);
        sr = 38'd14; vs_udr = 1'b1;
        tick(2);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("fp_level", fifo_level, 4);
        chk("fp_drop", drop_cnt, 1);
        chk("fp_head", jdo, 11);
        tick();
        vs_udr = 1'b0;
        tick(4);
        cmd_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            chk("fp_order", jdo, 64'(i));
            tick();
        end
        cmd_ready = 1'b0;
        chk("fp_empty", cmd_valid, 0);

        for (int i = 20; i <= 24; i++) dr_pulse(38'(i), 2'd0);
        chk("cd_drop2", drop_cnt, 2);
        sr = 38'd25; vs_udr = 1'b1;
        tick(2);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("cd_overrun", overrun, 1);
        chk("cd_drop", drop_cnt, 1);
        tick();
        vs_udr = 1'b0;
        tick(4);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("clr_overrun", overrun, 0);
        chk("clr_drop", drop_cnt, 0);
        for (int i = 0; i < 300; i++) dr_pulse(38'h3F_0000_0000, 2'd2);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_overrun", overrun, 1);
        chk("sat_level", fifo_level, 4);
        chk("sat_head", jdo, 20);

        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("mr_level3", fifo_level, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_level", fifo_level, 0);
        chk("mr_valid", cmd_valid, 0);
        chk("mr_cur_ir", cur_ir, 0);
        chk("mr_drop", drop_cnt, 0);
        chk("mr_jdo", jdo, 0);
        tick();
        reset_n = 1'b1;
        tick(4);

        sr = 38'h55; ir_in = 2'd1; vs_udr = 1'b1; vs_uir = 1'b1;
        tick(3);
        chk("both_cur_ir", cur_ir, 1);
        chk("both_cmd_ir", cmd_ir, 1);
        chk("both_jdo", jdo, 38'h55);
        chk("both_take", cmd_take, 4'b0010);
        chk("both_level", fifo_level, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
